nes_rate_counter: RTL and testbench

//  Single-clock successor to the NES-driven counter path. It merges the NES serial

---
 rtl/nes_rate_counter.sv | 174 +++++++++++++++++
 tb/tb_nes_rate_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nes_rate_counter.sv
// NES pad reader driving a rate-selectable up/down counter, all from one clock via enables.
// Optional: define COUNT_SATURATE_EN to clamp count at 0 / MAX_COUNT instead of wrapping.
module nes_rate_counter #(
  parameter int WIDTH       = 14,
  parameter int MAX_COUNT   = 9999,
  parameter int NES_DIV     = 32,
  parameter int POLL_CYCLES = 65536,
  parameter int RATE_DIV0   = 131072,
  parameter int RATE_DIV1   = 65536,
  parameter int RATE_DIV2   = 16384,
  parameter int RATE_DIV3   = 1024
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dataYellow,
  output logic             latchOrange,
  output logic             clockRed,
  output logic [7:0]       buttons,
  output logic             frame_valid,
  output logic [1:0]       rate_sel,
  output logic             count_step,
  output logic [WIDTH-1:0] count
);

  localparam int PW        = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW        = (NES_DIV > 1) ? $clog2(NES_DIV) : 1;
  localparam int DIV_MAX01 = (RATE_DIV0 > RATE_DIV1) ? RATE_DIV0 : RATE_DIV1;
  localparam int DIV_MAX23 = (RATE_DIV2 > RATE_DIV3) ? RATE_DIV2 : RATE_DIV3;
  localparam int DIV_MAX   = (DIV_MAX01 > DIV_MAX23) ? DIV_MAX01 : DIV_MAX23;
  localparam int SW        = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

`ifdef COUNT_SATURATE_EN
  localparam logic [WIDTH-1:0] UP_AT_MAX    = MAX_C;
  localparam logic [WIDTH-1:0] DOWN_AT_ZERO = '0;
`else
  localparam logic [WIDTH-1:0] UP_AT_MAX    = '0;
  localparam logic [WIDTH-1:0] DOWN_AT_ZERO = MAX_C;
`endif

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    poll_cnt;
  logic [TW-1:0]    tick;
  logic [4:0]       half_cnt;
  logic [7:0]       shift_reg;
  logic             start_prev;
  logic [1:0]       rate_next;
  logic [SW-1:0]    presc, presc_term;
  logic             poll_end, half_end, rate_change, start_clear, step_fire;
  logic [WIDTH-1:0] count_next;

  assign poll_end = (poll_cnt == PW'(POLL_CYCLES - 1));
  assign half_end = (tick == TW'(NES_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n || poll_end) poll_cnt <= '0;
    else                      poll_cnt <= poll_cnt + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Halves 0..1 are the latch pulse, halves 2..17 are the eight bits (even = clock high).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (poll_end)                      state_next = LATCH;
      LATCH:   if (half_end && half_cnt == 5'd1)  state_next = SHIFT;
      SHIFT:   if (half_end && half_cnt == 5'd17) state_next = DONE;
      DONE:                                       state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  always_comb begin
    latchOrange = (state == LATCH);
    clockRed    = !((state == SHIFT) && half_cnt[0]);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !(state == LATCH || state == SHIFT)) begin
      tick     <= '0;
      half_cnt <= '0;
    end else if (half_end) begin
      tick     <= '0;
      half_cnt <= half_cnt + 5'd1;
    end else begin
      tick     <= tick + TW'(1);
    end
  end

  // A arrives first, so after eight shifts it sits in bit 0.
  always_ff @(posedge clock) begin
    if (!reset_n)
      shift_reg <= '0;
    else if (state == SHIFT && !half_cnt[0] && half_end)
      shift_reg <= {dataYellow, shift_reg[7:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      buttons     <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (state == DONE);
      if (state == DONE) buttons <= ~shift_reg;
    end
  end

  always_comb begin
    rate_next = rate_sel;
    if (frame_valid) begin
      if      (buttons[4]) rate_next = 2'd3;
      else if (buttons[5]) rate_next = 2'd0;
      else if (buttons[6]) rate_next = 2'd1;
      else if (buttons[7]) rate_next = 2'd2;
    end
  end

  assign rate_change = (rate_next != rate_sel);
  assign start_clear = frame_valid && buttons[3] && !start_prev;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rate_sel   <= 2'd0;
      start_prev <= 1'b0;
    end else begin
      rate_sel <= rate_next;
      if (frame_valid) start_prev <= buttons[3];
    end
  end

  always_comb begin
    case (rate_sel)
      2'd0:    presc_term = SW'(RATE_DIV0 - 1);
      2'd1:    presc_term = SW'(RATE_DIV1 - 1);
      2'd2:    presc_term = SW'(RATE_DIV2 - 1);
      default: presc_term = SW'(RATE_DIV3 - 1);
    endcase
  end

  // A rate change restarts the step period and swallows any step due that cycle.
  assign step_fire = !rate_change && (presc == presc_term);

  always_ff @(posedge clock) begin
    if (!reset_n || rate_change || presc == presc_term) presc <= '0;
    else                                                presc <= presc + SW'(1);
  end

  always_comb begin
    count_next = count;
    if (buttons[0] && !buttons[1])
      count_next = (count == MAX_C) ? UP_AT_MAX : count + WIDTH'(1);
    else if (buttons[1] && !buttons[0])
      count_next = (count == '0) ? DOWN_AT_ZERO : count - WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || start_clear) begin
      count      <= '0;
      count_step <= 1'b0;
    end else if (step_fire) begin
      count      <= count_next;
      count_step <= 1'b1;
    end else begin
      count_step <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nes_rate_counter.sv
// Bench for nes_rate_counter: a controller model answers the serial reads and a
// cycle-indexed reference predicts every output from frame/step arithmetic.
module tb_nes_rate_counter;

  localparam int WIDTH       = 4;
  localparam int MAX_COUNT   = 9;
  localparam int NES_DIV     = 2;
  localparam int POLL_CYCLES = 64;
  localparam int RATE_DIV0   = 16;
  localparam int RATE_DIV1   = 8;
  localparam int RATE_DIV2   = 4;
  localparam int RATE_DIV3   = 2;
  localparam int LATCH_LEN   = 2 * NES_DIV;
  localparam int SHIFT_LEN   = 16 * NES_DIV;
  localparam int FRAME_LEN   = 18 * NES_DIV + 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             dataYellow;
  logic             latchOrange, clockRed, frame_valid, count_step;
  logic [7:0]       buttons;
  logic [1:0]       rate_sel;
  logic [WIDTH-1:0] count;

  nes_rate_counter #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .NES_DIV(NES_DIV), .POLL_CYCLES(POLL_CYCLES),
    .RATE_DIV0(RATE_DIV0), .RATE_DIV1(RATE_DIV1), .RATE_DIV2(RATE_DIV2), .RATE_DIV3(RATE_DIV3)
  ) dut (
    .clock(clock), .reset_n(reset_n), .dataYellow(dataYellow), .latchOrange(latchOrange),
    .clockRed(clockRed), .buttons(buttons), .frame_valid(frame_valid), .rate_sel(rate_sel),
    .count_step(count_step), .count(count)
  );

  always #5 clock = ~clock;

  // Controller: snapshot on latch, advance one button per rising shift clock.
  logic [7:0] pad = 8'h00;
  logic [7:0] pad_img = 8'h00;
  int         bit_idx = 8;

  always @(posedge latchOrange or posedge clockRed) begin
    if (latchOrange) begin
      pad_img = pad;
      bit_idx = 0;
    end else begin
      bit_idx = bit_idx + 1;
    end
  end

  always_comb dataYellow = (bit_idx < 8) ? ~pad_img[bit_idx[2:0]] : 1'b0;

  int checks = 0;
  int errors = 0;

  int         t;
  int         m_last, m_rate, m_count;
  bit         m_step, m_fv, m_prev_start;
  logic [7:0] m_buttons, m_latched;

  int  first_latch = -1;
  bit  mon_en = 1'b0;
  bit  prev_cr = 1'b1;
  int  latch_cycles = 0, low_cycles = 0, falls = 0;

  function automatic int rate_div(input int r);
    case (r)
      0:       return RATE_DIV0;
      1:       return RATE_DIV1;
      2:       return RATE_DIV2;
      default: return RATE_DIV3;
    endcase
  endfunction

  function automatic int next_count(input int c, input logic [7:0] b);
    if (b[0] && !b[1]) begin
`ifdef COUNT_SATURATE_EN
      return (c == MAX_COUNT) ? MAX_COUNT : c + 1;
`else
      return (c + 1) % (MAX_COUNT + 1);
`endif
    end else if (b[1] && !b[0]) begin
`ifdef COUNT_SATURATE_EN
      return (c == 0) ? 0 : c - 1;
`else
      return (c + MAX_COUNT) % (MAX_COUNT + 1);
`endif
    end
    return c;
  endfunction

  function automatic bit exp_latch();
    return (t >= POLL_CYCLES) && ((t % POLL_CYCLES) < LATCH_LEN);
  endfunction

  function automatic bit exp_clock_red();
    int o;
    o = t % POLL_CYCLES;
    if (t >= POLL_CYCLES && o >= LATCH_LEN && o < LATCH_LEN + SHIFT_LEN)
      return (((o - LATCH_LEN) / NES_DIV) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    t = 0; m_last = 0; m_rate = 0; m_count = 0;
    m_step = 1'b0; m_fv = 1'b0; m_prev_start = 1'b0;
    m_buttons = 8'h00; m_latched = 8'h00;
  endtask

  // Advance the reference by one clock edge t, using the values held before it.
  task automatic model_edge();
    int new_rate;
    bit clr, fire;
    t++;
    new_rate = m_rate;
    clr = 1'b0;
    if (m_fv) begin
      if      (m_buttons[4]) new_rate = 3;
      else if (m_buttons[5]) new_rate = 0;
      else if (m_buttons[6]) new_rate = 1;
      else if (m_buttons[7]) new_rate = 2;
      clr = m_buttons[3] && !m_prev_start;
      m_prev_start = m_buttons[3];
    end
    fire = (new_rate == m_rate) && (((t - m_last) % rate_div(m_rate)) == 0);
    if (new_rate != m_rate) begin
      m_rate = new_rate;
      m_last = t;
    end
    m_step = 1'b0;
    if (clr) m_count = 0;
    else if (fire) begin
      m_step = 1'b1;
      m_count = next_count(m_count, m_buttons);
    end
    if (t % POLL_CYCLES == 0) m_latched = pad;
    m_fv = (t >= POLL_CYCLES) && ((t % POLL_CYCLES) == FRAME_LEN);
    if (m_fv) m_buttons = m_latched;
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, t, observed, expected);
    end
  endtask

  task automatic checkOutput();
    check_val("latchOrange", {31'd0, latchOrange}, {31'd0, exp_latch()});
    check_val("clockRed", {31'd0, clockRed}, {31'd0, exp_clock_red()});
    check_val("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    check_val("buttons", {24'd0, buttons}, {24'd0, m_buttons});
    check_val("rate_sel", {30'd0, rate_sel}, m_rate);
    check_val("count_step", {31'd0, count_step}, {31'd0, m_step});
    check_val("count", {28'd0, count}, m_count);
  endtask

  task automatic run_cycle();
    @(posedge clock);
    #1;
    model_edge();
    if (latchOrange && first_latch < 0) first_latch = t;
    if (mon_en) begin
      if (latchOrange) latch_cycles++;
      if (!clockRed) low_cycles++;
      if (prev_cr && !clockRed) falls++;
      prev_cr = clockRed;
    end
    checkOutput();
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) begin
      @(posedge clock);
      #1;
      model_reset();
      checkOutput();
    end
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] p, input int cycles);
    pad = p;
    repeat (cycles) run_cycle();
  endtask

  initial begin
    $display("[TB] start");
    model_reset();
    #2;
    apply_reset(3);

    // First frame with only A pressed: timing of latch and shift pulses.
    mon_en = 1'b1;
    applyStimulus(8'h01, 110);
    mon_en = 1'b0;
    check_val("first_latch_cycle", first_latch, 64);
    check_val("latch_high_cycles", latch_cycles, LATCH_LEN);
    check_val("clock_low_cycles", low_cycles, 8 * NES_DIV);
    check_val("clock_low_pulses", falls, 8);
    check_val("buttons_a_only", {24'd0, buttons}, 32'h01);

    applyStimulus(8'h11, 64);
    check_val("rate_up", {30'd0, rate_sel}, 32'd3);

    applyStimulus(8'h42, 64);
    check_val("rate_left", {30'd0, rate_sel}, 32'd1);

    applyStimulus(8'h01, 64);
    applyStimulus(8'h09, 56);
    check_val("start_clear_count", {28'd0, count}, 32'd0);
    check_val("start_clear_nostep", {31'd0, count_step}, 32'd0);
    applyStimulus(8'h09, 136);

    // Reset while bit 4 is being shifted.
    applyStimulus(8'h01, 38);
    apply_reset(1);
    check_val("midframe_latch", {31'd0, latchOrange}, 32'd0);
    check_val("midframe_clock", {31'd0, clockRed}, 32'd1);
    check_val("midframe_buttons", {24'd0, buttons}, 32'd0);
    applyStimulus(8'h81, 110);
    check_val("buttons_after_reset", {24'd0, buttons}, 32'h81);
    check_val("rate_right", {30'd0, rate_sel}, 32'd2);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 7) == 0) apply_reset(1);
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(20, 90));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
